// File: rtl/reg_file_sb.sv
// Datapath register file with async reset, optional hardwired R0, write-to-read bypass,
// per-register pending-write scoreboard and a one-register-per-cycle clear sweep.
module reg_file_sb #(
  parameter int W       = 8,
  parameter int A       = 3,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               WriteEn,
  input  logic [A-1:0]       Waddr,
  input  logic [W-1:0]       DataIn,
  input  logic [NRD*A-1:0]   Raddr,
  output logic [NRD*W-1:0]   DataOut,
  output logic [NRD-1:0]     RdBusy,
  input  logic               Issue,
  input  logic [A-1:0]       IssueAddr,
  output logic               IssueAccept,
  output logic [2**A-1:0]    BusyVec,
  input  logic               ClearAll,
  output logic               Ready
);

  localparam int DEPTH = 2**A;
  localparam logic [A-1:0] CNT_LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t       state_reg, state_next;
  logic [A-1:0] cnt_reg, cnt_next;

  logic         sweeping;
  logic         wr_drop;
  logic         wr_ok;
  logic         issue_set;
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The counter wraps to zero exactly when the last register is swept, so the
  // A-bit width is sufficient and the exit test never aliases.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (ClearAll) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt_reg + A'(1);
        if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign Ready       = (state_reg == IDLE);
  assign sweeping    = (state_reg == CLEAR);
  assign wr_drop     = (ZERO_R0 != 0) && (Waddr == '0);
  assign wr_ok       = WriteEn && Ready && !wr_drop;
  // Acceptance looks only at the registered busy bit; a same-cycle writeback cannot unblock it.
  assign IssueAccept = Issue && Ready && !BusyVec[IssueAddr];
  assign issue_set   = IssueAccept && !((ZERO_R0 != 0) && (IssueAddr == '0));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [W-1:0] data_reg;
      logic         busy_reg;
      logic         sweep_hit;
      logic         wr_hit;
      logic         iss_hit;

      assign sweep_hit = sweeping && (cnt_reg == A'(gi));
      assign wr_hit    = wr_ok && (Waddr == A'(gi));
      assign iss_hit   = issue_set && (IssueAddr == A'(gi));

      // Issue beats writeback on the busy bit when both target this register.
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else if (sweep_hit) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else begin
          if (wr_hit) begin
            data_reg <= DataIn;
          end
          if (iss_hit) begin
            busy_reg <= 1'b1;
          end else if (wr_hit) begin
            busy_reg <= 1'b0;
          end
        end
      end

      assign mem_q[gi]   = data_reg;
      assign BusyVec[gi] = busy_reg;
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [A-1:0] ra;
      logic [W-1:0] rdata;
      logic         rbusy;

      assign ra = Raddr[gi*A +: A];

      always_comb begin
        rdata = mem_q[ra];
        rbusy = BusyVec[ra];
        if ((BYPASS != 0) && wr_ok && (Waddr == ra)) begin
          rdata = DataIn;
          rbusy = 1'b0;
        end
        if ((ZERO_R0 != 0) && (ra == '0)) begin
          rdata = '0;
          rbusy = 1'b0;
        end
      end

      assign DataOut[gi*W +: W] = rdata;
      assign RdBusy[gi]         = rbusy;
    end
  endgenerate

endmodule
